// File: rtl/wishbone_mem_responder.sv
// Pipelined Wishbone B4 slave holding the board tile RAM, with a clear engine that stalls the bus while it runs.
// Optional macro WB_MEM_RESPONDER_ERR_EN: answers out-of-range requests with wb_err_o instead of wb_ack_o.
module wishbone_mem_responder #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int MEM_WORDS = 240,
  parameter int ACK_LAT = 1,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [ADDR_W-1:0] wb_adr_i,
  input  logic [DATA_W-1:0] wb_dat_i,
  output logic [DATA_W-1:0] wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_stall_o,
  input  logic              clear_start,
  output logic              clear_busy
`ifdef WB_MEM_RESPONDER_ERR_EN
  ,
  output logic              wb_err_o
`endif
);

  localparam int CNT_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  logic [CNT_W-1:0]  clr_cnt;
  logic [DATA_W-1:0] mem [MEM_WORDS];
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] dat0;
  logic [DATA_W-1:0] dat_last;
  logic [ACK_LAT-1:0] ack_p;
  logic              acc;
  logic              in_range;
  logic              resp_ok;
  logic              rd0;
  logic [CNT_W-1:0]  idx;

  assign acc      = wb_cyc_i & wb_stb_i & ~wb_stall_o;
  assign in_range = {1'b0, wb_adr_i} < (ADDR_W+1)'(MEM_WORDS);
  assign idx      = wb_adr_i[CNT_W-1:0];

`ifdef WB_MEM_RESPONDER_ERR_EN
  logic [ACK_LAT-1:0] err_p;
  assign resp_ok  = in_range;
  assign wb_err_o = err_p[ACK_LAT-1];
`else
  assign resp_ok  = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      clr_cnt    <= '0;
      wb_stall_o <= 1'b0;
      clear_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clear_start) begin
            state      <= CLEAR;
            wb_stall_o <= 1'b1;
            clear_busy <= 1'b1;
          end
        end
        CLEAR: begin
          if (clr_cnt == CNT_W'(MEM_WORDS - 1)) begin
            clr_cnt    <= '0;
            state      <= IDLE;
            wb_stall_o <= 1'b0;
            clear_busy <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // No request is accepted while clearing, so the clear engine owns the single write port then.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_cnt] <= CLEAR_VAL;
    end else if (acc && wb_we_i && in_range) begin
      mem[idx] <= wb_dat_i;
    end
    if (acc && !wb_we_i && in_range) begin
      ram_q <= mem[idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_p <= '0;
      rd0   <= 1'b0;
`ifdef WB_MEM_RESPONDER_ERR_EN
      err_p <= '0;
`endif
    end else if (!wb_cyc_i) begin
      ack_p <= '0;
      rd0   <= 1'b0;
`ifdef WB_MEM_RESPONDER_ERR_EN
      err_p <= '0;
`endif
    end else begin
      for (int i = ACK_LAT - 1; i > 0; i--) begin
        ack_p[i] <= ack_p[i-1];
      end
      ack_p[0] <= acc & resp_ok;
      rd0      <= acc & ~wb_we_i & in_range;
`ifdef WB_MEM_RESPONDER_ERR_EN
      for (int i = ACK_LAT - 1; i > 0; i--) begin
        err_p[i] <= err_p[i-1];
      end
      err_p[0] <= acc & ~in_range;
`endif
    end
  end

  // First stage data comes straight from the RAM output register; later stages only delay it.
  assign dat0 = rd0 ? ram_q : '0;

  if (ACK_LAT == 1) begin : g_lat1
    assign dat_last = dat0;
  end else begin : g_latn
    logic [DATA_W-1:0] dly [ACK_LAT-1];
    always_ff @(posedge clk or posedge rst) begin
      if (rst || !wb_cyc_i) begin
        for (int i = 0; i < ACK_LAT - 1; i++) dly[i] <= '0;
      end else begin
        dly[0] <= dat0;
        for (int i = 1; i < ACK_LAT - 1; i++) dly[i] <= dly[i-1];
      end
    end
    assign dat_last = dly[ACK_LAT-2];
  end

  assign wb_ack_o = ack_p[ACK_LAT-1];
  assign wb_dat_o = dat_last;

endmodule

// File: tb/tb_wishbone_mem_responder.sv
// Bench for wishbone_mem_responder: two instances (ack latency 1 and 3) driven identically and compared
// every cycle against an array-based reference of memory contents, response schedule and clear timing.
module tb_wishbone_mem_responder;
  localparam int MW = 240;
  localparam int NCYC = 5000;
  localparam logic [7:0] CV = 8'h00;
`ifdef WB_MEM_RESPONDER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic cyc = 1'b0, stb = 1'b0, we = 1'b0, clr = 1'b0;
  logic [7:0] adr = '0, wdat = '0;
  logic [7:0] dat1, dat3;
  logic ack1, ack3, stall1, stall3, busy1, busy3;
  logic err1, err3;

  wishbone_mem_responder #(.DATA_W(8), .ADDR_W(8), .MEM_WORDS(MW), .ACK_LAT(1), .CLEAR_VAL(CV)) u_dut1 (
    .clk(clk), .rst(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr),
    .wb_dat_i(wdat), .wb_dat_o(dat1), .wb_ack_o(ack1), .wb_stall_o(stall1),
    .clear_start(clr), .clear_busy(busy1)
`ifdef WB_MEM_RESPONDER_ERR_EN
    , .wb_err_o(err1)
`endif
  );

  wishbone_mem_responder #(.DATA_W(8), .ADDR_W(8), .MEM_WORDS(MW), .ACK_LAT(3), .CLEAR_VAL(CV)) u_dut3 (
    .clk(clk), .rst(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr),
    .wb_dat_i(wdat), .wb_dat_o(dat3), .wb_ack_o(ack3), .wb_stall_o(stall3),
    .clear_start(clr), .clear_busy(busy3)
`ifdef WB_MEM_RESPONDER_ERR_EN
    , .wb_err_o(err3)
`endif
  );

`ifndef WB_MEM_RESPONDER_ERR_EN
  assign err1 = 1'b0;
  assign err3 = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  int edge_n = 0;
  int clear_left = 0;
  logic [7:0] ref_mem [256];
  logic [1:0] ekind [2][NCYC];   // 0 none, 1 ack, 2 err, indexed by edge after which it is visible
  logic [7:0] edat  [2][NCYC];

  function automatic int lat_of(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, edge_n, got, exp);
    end
  endtask

  task automatic check_dut(int k, logic a, logic [7:0] d, logic s, logic b, logic e);
    string sfx;
    sfx = (k == 0) ? "_lat1" : "_lat3";
    check_val({"ack", sfx}, {31'd0, a}, {31'd0, ekind[k][edge_n] == 2'd1});
    check_val({"dat", sfx}, {24'd0, d}, (ekind[k][edge_n] == 2'd1) ? {24'd0, edat[k][edge_n]} : 32'd0);
    check_val({"stall", sfx}, {31'd0, s}, {31'd0, clear_left > 0});
    check_val({"busy", sfx}, {31'd0, b}, {31'd0, clear_left > 0});
    if (ERR_EN) check_val({"err", sfx}, {31'd0, e}, {31'd0, ekind[k][edge_n] == 2'd2});
  endtask

  task automatic drive(bit c, bit s, bit w, logic [7:0] a, logic [7:0] d, bit cl);
    cyc = c; stb = s; we = w; adr = a; wdat = d; clr = cl;
  endtask

  // Advance one clock: predict from current inputs, take the edge, compare at the falling edge.
  task automatic step();
    logic acc, inr;
    logic [7:0] rd;
    acc = cyc && stb && (clear_left == 0);
    edge_n++;
    if (!cyc) begin
      for (int k = 0; k < 2; k++)
        for (int j = edge_n; j < edge_n + 4; j++) begin
          ekind[k][j] = 2'd0;
          edat[k][j] = 8'd0;
        end
    end
    if (acc) begin
      inr = (adr < MW);
      rd = (!we && inr) ? ref_mem[adr] : 8'd0;
      for (int k = 0; k < 2; k++) begin
        ekind[k][edge_n + lat_of(k) - 1] = (inr || !ERR_EN) ? 2'd1 : 2'd2;
        edat[k][edge_n + lat_of(k) - 1] = rd;
      end
      if (we && inr) ref_mem[adr] = wdat;
    end
    if (clear_left > 0) begin
      clear_left--;
    end else if (clr) begin
      clear_left = MW;
      for (int i = 0; i < MW; i++) ref_mem[i] = CV;
    end
    @(posedge clk);
    @(negedge clk);
    check_dut(0, ack1, dat1, stall1, busy1, err1);
    check_dut(1, ack3, dat3, stall3, busy3, err3);
  endtask

  task automatic idle(int n, bit c);
    drive(c, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < NCYC; j++) begin
        ekind[k][j] = 2'd0;
        edat[k][j] = 8'd0;
      end
    @(negedge clk);
    @(negedge clk);
    check_val("rst_ack_lat1", {31'd0, ack1}, 32'd0);
    check_val("rst_dat_lat1", {24'd0, dat1}, 32'd0);
    check_val("rst_stall_lat1", {31'd0, stall1}, 32'd0);
    check_val("rst_busy_lat1", {31'd0, busy1}, 32'd0);
    check_val("rst_ack_lat3", {31'd0, ack3}, 32'd0);
    check_val("rst_dat_lat3", {24'd0, dat3}, 32'd0);
    check_val("rst_stall_lat3", {31'd0, stall3}, 32'd0);
    check_val("rst_busy_lat3", {31'd0, busy3}, 32'd0);
    rst = 1'b0;
    idle(2, 1'b1);

    // single write then read
    drive(1, 1, 1, 8'd5, 8'hA7, 0); step();
    drive(1, 1, 0, 8'd5, 8'h00, 0); step();
    idle(4, 1'b1);

    // back-to-back writes and reads
    for (int i = 0; i < 4; i++) begin drive(1, 1, 1, 8'(i), 8'(8'h10 + i), 0); step(); end
    for (int i = 0; i < 4; i++) begin drive(1, 1, 0, 8'(i), 8'h00, 0); step(); end
    idle(4, 1'b1);

    // clear, with a read held against the stall the whole time
    drive(1, 0, 0, 8'd0, 8'd0, 1); step();
    drive(1, 1, 0, 8'd0, 8'd0, 0);
    for (int i = 0; i < 241; i++) step();
    drive(1, 1, 0, 8'd239, 8'd0, 0); step();
    idle(4, 1'b1);

    // read in the same cycle as clear_start, plus a second start mid-clear
    drive(1, 1, 1, 8'd9, 8'h3C, 0); step();
    drive(1, 1, 0, 8'd9, 8'h00, 1); step();
    idle(100, 1'b1);
    drive(1, 0, 0, 8'd0, 8'd0, 1); step();
    idle(145, 1'b1);
    drive(1, 1, 0, 8'd9, 8'h00, 0); step();
    idle(4, 1'b1);

    // cycle abort right after an accepted write
    drive(1, 1, 1, 8'd7, 8'h55, 0); step();
    idle(5, 1'b0);
    drive(1, 1, 0, 8'd7, 8'h00, 0); step();
    idle(4, 1'b1);

    // address boundaries
    drive(1, 1, 0, 8'd250, 8'h00, 0); step();
    drive(1, 1, 1, 8'd250, 8'hEE, 0); step();
    drive(1, 1, 0, 8'd250, 8'h00, 0); step();
    drive(1, 1, 1, 8'd239, 8'h77, 0); step();
    drive(1, 1, 1, 8'd240, 8'h99, 0); step();
    drive(1, 1, 0, 8'd239, 8'h00, 0); step();
    drive(1, 1, 0, 8'd240, 8'h00, 0); step();
    idle(4, 1'b1);

    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      drive(($urandom % 16) != 0, ($urandom % 4) != 0, $urandom % 2,
            (($urandom % 8) == 0) ? 8'($urandom_range(240, 255)) : 8'($urandom_range(0, 239)),
            8'($urandom), ($urandom % 400) == 0);
      step();
    end
    idle(6, 1'b1);

    // async reset in the middle of a clear
    drive(1, 0, 0, 8'd0, 8'd0, 1); step();
    idle(50, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_val("rst_mid_stall_lat1", {31'd0, stall1}, 32'd0);
    check_val("rst_mid_busy_lat1", {31'd0, busy1}, 32'd0);
    check_val("rst_mid_stall_lat3", {31'd0, stall3}, 32'd0);
    check_val("rst_mid_busy_lat3", {31'd0, busy3}, 32'd0);
    clear_left = 0;
    cyc = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle(4, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
